time_display_scanner: RTL and testbench

//   Reader side of the game-clock BCD bus. Takes the 16-bit packed BCD time word
//   {min_tens, min_ones, sec_tens, sec_ones} and drives a 4-digit multiplexed

---
 rtl/time_disp_pkg.sv | 29 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/time_display_scanner.sv | 111 +++++++++++
 tb/tb_time_display_scanner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/time_disp_pkg.sv
// Shared constants for the time display: active-high segment patterns (gfedcba order),
// the digit count, and a helper that flags packed BCD words holding a non-decimal nibble.
package time_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic has_non_bcd(input logic [15:0] value);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (value[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to seven-segment decoder, active-high output.
// Anything above 9 renders as a dash so corrupt time words are visible on the board.
module bcd_to_seg7
  import time_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scanner.sv
// Scans a packed BCD mm:ss word onto a 4-digit multiplexed seven-segment display with a
// blinking colon, optional leading-zero blanking and a non-BCD flag.
module time_display_scanner
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 125,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        blank_leading,
  input  logic [15:0] time_value,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        digit_err
);

  localparam int CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  // Polarity lives only here: everything upstream of the output registers is active-high.
  localparam logic       ACT_LOW  = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_MASK = {7{ACT_LOW}};
  localparam logic [3:0] AN_MASK  = {4{ACT_LOW}};

  logic [CW-1:0]    scan_cnt;
  logic [IDX_W-1:0] dig_idx;
  logic [15:0]      snap;
  logic [BW-1:0]    blink_cnt;
  logic             colon;

  logic       tick;
  logic       frame_wrap;
  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic [6:0] seg_pat;
  logic [3:0] an_pat;
  logic       dp_pat;

  assign tick       = (scan_cnt == CW'(SCAN_DIV - 1));
  assign frame_wrap = tick && (dig_idx == IDX_W'(NUM_DIGITS - 1));
  assign cur_nib    = snap[{dig_idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .digit (cur_nib),
    .seg   (dec_seg)
  );

  always_comb begin
    seg_pat = dec_seg;
    if (blank_leading && (dig_idx == IDX_W'(NUM_DIGITS - 1)) && (snap[15:12] == 4'd0))
      seg_pat = SEG_OFF;
    an_pat = 4'b0001 << dig_idx;
    dp_pat = colon && (dig_idx == IDX_W'(2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt   <= '0;
      dig_idx    <= '0;
      snap       <= '0;
      blink_cnt  <= '0;
      colon      <= 1'b0;
      frame_done <= 1'b0;
      digit_err  <= 1'b0;
      seg        <= SEG_OFF ^ SEG_MASK;
      an         <= AN_MASK;
      dp         <= ACT_LOW;
    end else if (!enable) begin
      // Display dark; snapshot tracks the input so re-enable shows the current time at once.
      scan_cnt   <= '0;
      dig_idx    <= '0;
      snap       <= time_value;
      blink_cnt  <= '0;
      colon      <= 1'b0;
      frame_done <= 1'b0;
      digit_err  <= has_non_bcd(time_value);
      seg        <= SEG_OFF ^ SEG_MASK;
      an         <= AN_MASK;
      dp         <= ACT_LOW;
    end else begin
      frame_done <= frame_wrap;
      seg        <= seg_pat ^ SEG_MASK;
      an         <= an_pat ^ AN_MASK;
      dp         <= dp_pat ^ ACT_LOW;
      if (tick) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      // Snapshot only at the frame boundary so a frame never mixes two time values.
      if (frame_wrap) begin
        snap      <= time_value;
        digit_err <= has_non_bcd(time_value);
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          colon     <= ~colon;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_time_display_scanner.sv
// Directed bench for time_display_scanner at SCAN_DIV=4, BLINK_FRAMES=2, active-low outputs.
// Expected segment codes are hand-derived active-low gfedcba patterns.
module tb_time_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        blank_leading;
  logic [15:0] time_value;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        digit_err;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] AN_EXP [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clk = ~clk;

  time_display_scanner #(
    .SCAN_DIV       (4),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .blank_leading (blank_leading),
    .time_value    (time_value),
    .seg           (seg),
    .dp            (dp),
    .an            (an),
    .frame_done    (frame_done),
    .digit_err     (digit_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One disabled cycle loads the snapshot and clears the scan; the next step is the first shown cycle.
  task automatic restart(input logic [15:0] tv);
    enable     = 1'b0;
    time_value = tv;
    step();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    enable        = 1'b0;
    blank_leading = 1'b0;
    time_value    = 16'h0000;
    step();
    step();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=F", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7F", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL reset_digit_err got=%b exp=0", digit_err); end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    int d;
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    restart(16'h1234);
    for (int i = 0; i < 32; i++) begin
      step();
      d = (i / 4) % 4;
      checks++; if (an !== AN_EXP[d]) begin errors++; $display("FAIL scan_an cyc=%0d got=%h exp=%h", i, an, AN_EXP[d]); end
      checks++; if (seg !== exp_seg[d]) begin errors++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", i, seg, exp_seg[d]); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp cyc=%0d got=%b exp=1", i, dp); end
      checks++; if (frame_done !== (i % 16 == 15)) begin errors++; $display("FAIL scan_frame_done cyc=%0d got=%b exp=%b", i, frame_done, (i % 16 == 15)); end
    end
    checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL scan_digit_err got=%b exp=0", digit_err); end
  endtask

  task automatic test_snapshot();
    logic [6:0] old_seg [4];
    logic [6:0] new_seg [4];
    logic [6:0] exp;
    int d;
    old_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    new_seg = '{7'h10, 7'h12, 7'h10, 7'h12};
    restart(16'h1234);
    for (int i = 0; i < 32; i++) begin
      step();
      d   = (i / 4) % 4;
      exp = (i < 16) ? old_seg[d] : new_seg[d];
      checks++; if (an !== AN_EXP[d]) begin errors++; $display("FAIL snap_an cyc=%0d got=%h exp=%h", i, an, AN_EXP[d]); end
      checks++; if (seg !== exp) begin errors++; $display("FAIL snap_seg cyc=%0d got=%h exp=%h", i, seg, exp); end
      if (i == 4) time_value = 16'h5959;
    end
  endtask

  task automatic test_blank();
    logic [6:0] exp_seg [4];
    int d;
    exp_seg = '{7'h12, 7'h40, 7'h10, 7'h7F};
    blank_leading = 1'b1;
    restart(16'h0905);
    for (int i = 0; i < 32; i++) begin
      step();
      d = (i / 4) % 4;
      checks++; if (an !== AN_EXP[d]) begin errors++; $display("FAIL blank_an cyc=%0d got=%h exp=%h", i, an, AN_EXP[d]); end
      checks++; if (seg !== exp_seg[d]) begin errors++; $display("FAIL blank_seg cyc=%0d got=%h exp=%h", i, seg, exp_seg[d]); end
      if (i == 15) begin
        blank_leading = 1'b0;
        exp_seg[3]    = 7'h40;
      end
    end
  endtask

  task automatic test_err();
    logic [6:0] ok_seg [4];
    logic [6:0] bad_seg [4];
    logic [6:0] exp;
    logic       exp_err;
    int d;
    ok_seg  = '{7'h40, 7'h40, 7'h10, 7'h40};
    bad_seg = '{7'h40, 7'h40, 7'h3F, 7'h40};
    restart(16'h0900);
    time_value = 16'h0A00;
    for (int i = 0; i < 48; i++) begin
      step();
      d       = (i / 4) % 4;
      exp     = (i >= 16 && i < 32) ? bad_seg[d] : ok_seg[d];
      exp_err = (i >= 15 && i < 31);
      checks++; if (seg !== exp) begin errors++; $display("FAIL err_seg cyc=%0d got=%h exp=%h", i, seg, exp); end
      checks++; if (digit_err !== exp_err) begin errors++; $display("FAIL err_flag cyc=%0d got=%b exp=%b", i, digit_err, exp_err); end
      if (i == 15) time_value = 16'h0900;
    end
  endtask

  task automatic test_colon();
    logic exp_dp;
    int d;
    int f;
    restart(16'h1234);
    for (int i = 0; i < 96; i++) begin
      step();
      d      = (i / 4) % 4;
      f      = i / 16;
      exp_dp = (d == 2 && (f == 2 || f == 3)) ? 1'b0 : 1'b1;
      checks++; if (dp !== exp_dp) begin errors++; $display("FAIL colon_dp cyc=%0d got=%b exp=%b", i, dp, exp_dp); end
    end
  endtask

  task automatic test_enable_drop();
    logic [6:0] exp_seg [4];
    int d;
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    restart(16'h1234);
    for (int i = 0; i < 42; i++) step();
    checks++; if (an !== 4'hB) begin errors++; $display("FAIL drop_pre_an got=%h exp=B", an); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL drop_pre_dp got=%b exp=0", dp); end
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (an !== 4'hF) begin errors++; $display("FAIL drop_an cyc=%0d got=%h exp=F", i, an); end
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL drop_seg cyc=%0d got=%h exp=7F", i, seg); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL drop_dp cyc=%0d got=%b exp=1", i, dp); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL drop_frame_done cyc=%0d got=%b exp=0", i, frame_done); end
    end
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      d = i / 4;
      checks++; if (an !== AN_EXP[d]) begin errors++; $display("FAIL reen_an cyc=%0d got=%h exp=%h", i, an, AN_EXP[d]); end
      checks++; if (seg !== exp_seg[d]) begin errors++; $display("FAIL reen_seg cyc=%0d got=%h exp=%h", i, seg, exp_seg[d]); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reen_dp cyc=%0d got=%b exp=1", i, dp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp;
    int d;
    restart(16'h0A34);
    for (int i = 0; i < 6; i++) step();
    checks++; if (digit_err !== 1'b1) begin errors++; $display("FAIL mid_pre_err got=%b exp=1", digit_err); end
    reset = 1'b1;
    step();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL mid_an got=%h exp=F", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL mid_seg got=%h exp=7F", seg); end
    checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL mid_err got=%b exp=0", digit_err); end
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      d   = (i / 4) % 4;
      exp = (i < 16) ? 7'h40 : ((d == 0) ? 7'h19 : 7'h30);
      checks++; if (an !== AN_EXP[d]) begin errors++; $display("FAIL mid_scan_an cyc=%0d got=%h exp=%h", i, an, AN_EXP[d]); end
      checks++; if (seg !== exp) begin errors++; $display("FAIL mid_scan_seg cyc=%0d got=%h exp=%h", i, seg, exp); end
      checks++; if (frame_done !== (i == 15)) begin errors++; $display("FAIL mid_frame_done cyc=%0d got=%b exp=%b", i, frame_done, (i == 15)); end
      checks++; if (digit_err !== (i >= 15)) begin errors++; $display("FAIL mid_scan_err cyc=%0d got=%b exp=%b", i, digit_err, (i >= 15)); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blank();
    test_err();
    test_colon();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
